mon_frame_tx: RTL and testbench

- Transmit-side neighbour of the monitor-bus receive path: accepts 40-bit monitor words over a valid/ready handshake and serialises them onto from_mon, one bit per mon_clk.
- Holds a 2-entry input buffer so the producer can queue the next word while the current frame shifts out.
- Sits between the word source (command/debug logic) and the from_mon pin, which it drives directly.

---
 rtl/mon_pkg.sv | 18 +
 rtl/mon_tx_fifo.sv | 63 ++++++
 rtl/mon_frame_tx.sv | 144 ++++++++++++++
 tb/tb_mon_frame_tx.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mon_pkg.sv
// Shared types and constants for the monitor-bus transmit path.
package mon_pkg;

  localparam int MON_DATA_W = 40;
  localparam int CNT_W      = 6;

  localparam logic START_BIT = 1'b1;
  localparam logic IDLE_LVL  = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    GAP
  } tx_state_t;

endpackage

// File: rtl/mon_tx_fifo.sv
// Two-entry word buffer in front of the monitor-bus serialiser.
module mon_tx_fifo
  import mon_pkg::*;
#(
  parameter int DATA_W = MON_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [1:0]        count_o
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              push_ok, pop_ok;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d = wr_ptr_q ^ push_ok;
    rd_ptr_d = rd_ptr_q ^ pop_ok;
    count_d  = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/mon_frame_tx.sv
// Monitor-bus frame serialiser: start bit, DATA_W bits MSB first, optional parity, GAP_BITS idle zeros.
// Optional even-parity bit after the data is enabled by defining MON_TX_PARITY_EN.
module mon_frame_tx
  import mon_pkg::*;
#(
  parameter int DATA_W   = MON_DATA_W,
  parameter int GAP_BITS = 2
) (
  input  logic              mon_clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              from_mon,
  output logic              busy,
  output logic              tx_done
);

  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_BITS - 1);

  tx_state_t         state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] shift_q;
  logic              from_mon_q;
  logic              tx_done_q;
  logic              busy_q;
`ifdef MON_TX_PARITY_EN
  logic              parity_q;
`endif

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [1:0]        fifo_count;
  logic [DATA_W-1:0] fifo_head;

  // in_ready depends only on the registered fill level, never on in_valid.
  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && in_ready;
  assign fifo_pop  = !fifo_empty &&
                     ((state_q == IDLE) || ((state_q == GAP) && (cnt_q == GAP_LAST)));

  mon_tx_fifo #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk_i   (mon_clk),
    .rst_i   (reset),
    .push_i  (fifo_push),
    .data_i  (in_data),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign from_mon = from_mon_q;
  assign tx_done  = tx_done_q;
  assign busy     = busy_q;

  // Every output is registered from the pre-edge state, so busy lines up with the bit on from_mon.
  always_ff @(posedge mon_clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      from_mon_q <= IDLE_LVL;
      tx_done_q  <= 1'b0;
      busy_q     <= 1'b0;
`ifdef MON_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      tx_done_q <= 1'b0;
      busy_q    <= (state_q != IDLE) || (fifo_count != 2'd0);
      case (state_q)
        IDLE: begin
          from_mon_q <= IDLE_LVL;
          if (fifo_pop) begin
            shift_q  <= fifo_head;
`ifdef MON_TX_PARITY_EN
            parity_q <= ^fifo_head;
`endif
            cnt_q    <= '0;
            state_q  <= START;
          end
        end
        START: begin
          from_mon_q <= START_BIT;
          cnt_q      <= '0;
          state_q    <= DATA;
        end
        DATA: begin
          from_mon_q <= shift_q[DATA_W-1];
          shift_q    <= {shift_q[DATA_W-2:0], 1'b0};
          if (cnt_q == DATA_LAST) begin
            cnt_q <= '0;
`ifdef MON_TX_PARITY_EN
            state_q <= PARITY;
`else
            state_q <= GAP;
`endif
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
`ifdef MON_TX_PARITY_EN
        PARITY: begin
          from_mon_q <= parity_q;
          cnt_q      <= '0;
          state_q    <= GAP;
        end
`endif
        GAP: begin
          from_mon_q <= IDLE_LVL;
          if (cnt_q == GAP_LAST) begin
            tx_done_q <= 1'b1;
            cnt_q     <= '0;
            // A queued word skips IDLE so the spacing stays exactly GAP_BITS.
            if (fifo_pop) begin
              shift_q  <= fifo_head;
`ifdef MON_TX_PARITY_EN
              parity_q <= ^fifo_head;
`endif
              state_q  <= START;
            end else begin
              state_q  <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          from_mon_q <= IDLE_LVL;
          cnt_q      <= '0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mon_frame_tx.sv
// Directed self-checking bench for mon_frame_tx (GAP_BITS=2 and GAP_BITS=5 instances).
module tb_mon_frame_tx;

  localparam int DW = 40;
`ifdef MON_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FL2 = 1 + DW + PAR + 2;
  localparam int FL5 = 1 + DW + PAR + 5;

  logic          mon_clk;
  logic          reset;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          sel5;

  logic in_valid2, in_ready2, from_mon2, busy2, tx_done2;
  logic in_valid5, in_ready5, from_mon5, busy5, tx_done5;
  logic cur_line, cur_done, cur_busy, cur_ready;

  assign in_valid2 = in_valid && !sel5;
  assign in_valid5 = in_valid && sel5;
  assign cur_line  = sel5 ? from_mon5 : from_mon2;
  assign cur_done  = sel5 ? tx_done5  : tx_done2;
  assign cur_busy  = sel5 ? busy5     : busy2;
  assign cur_ready = sel5 ? in_ready5 : in_ready2;

  mon_frame_tx #(.DATA_W(DW), .GAP_BITS(2)) dut (
    .mon_clk  (mon_clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid2),
    .in_ready (in_ready2),
    .from_mon (from_mon2),
    .busy     (busy2),
    .tx_done  (tx_done2)
  );

  mon_frame_tx #(.DATA_W(DW), .GAP_BITS(5)) dut_g5 (
    .mon_clk  (mon_clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid5),
    .in_ready (in_ready5),
    .from_mon (from_mon5),
    .busy     (busy5),
    .tx_done  (tx_done5)
  );

  initial mon_clk = 1'b0;
  always #5 mon_clk = ~mon_clk;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [DW-1:0] pend_q[$];
  int            acc_idx[$];
  logic [DW-1:0] acc_word[$];
  logic          cap_line[$], cap_done[$], cap_busy[$], cap_ready[$];
  logic          exp_line[$], exp_done[$], exp_bhi[$], exp_blo[$];
  int            exp_fit;
  int            bad_idx;
  logic          bad_act, bad_exp;
  int            nbad;

  // Sample at each falling edge, then present the next word; transfers happen on the following rising edge.
  task automatic run_stream(input int ncyc, input bit junk);
    cap_line.delete(); cap_done.delete(); cap_busy.delete(); cap_ready.delete();
    acc_idx.delete(); acc_word.delete();
    for (int c = 0; c < ncyc; c++) begin
      @(negedge mon_clk);
      cap_line.push_back(cur_line);
      cap_done.push_back(cur_done);
      cap_busy.push_back(cur_busy);
      cap_ready.push_back(cur_ready);
      if (pend_q.size() != 0) begin
        in_valid = 1'b1;
        if (cur_ready === 1'b1) begin
          in_data = pend_q.pop_front();
          acc_idx.push_back(c);
          acc_word.push_back(in_data);
        end else if (junk) begin
          in_data = {8'hC3, 32'(c)};
        end else begin
          in_data = pend_q[0];
        end
      end else begin
        in_valid = 1'b0;
        in_data  = '0;
      end
    end
  endtask

  // Reference timeline: start bit three samples after acceptance, frames never overlap.
  task automatic build_expected();
    int n        = cap_line.size();
    int g        = sel5 ? 5 : 2;
    int fl       = 1 + DW + PAR + g;
    int prev_end = 0;
    int s;
    exp_line.delete(); exp_done.delete(); exp_bhi.delete(); exp_blo.delete();
    for (int k = 0; k < n; k++) begin
      exp_line.push_back(1'b0); exp_done.push_back(1'b0);
      exp_bhi.push_back(1'b0);  exp_blo.push_back(1'b0);
    end
    exp_fit = 1;
    for (int j = 0; j < acc_idx.size(); j++) begin
      s = acc_idx[j] + 3;
      if (s < prev_end) s = prev_end;
      if (s + fl >= n) begin
        exp_fit = 0;
      end else begin
        exp_line[s] = 1'b1;
        for (int b = 0; b < DW; b++) exp_line[s+1+b] = acc_word[j][DW-1-b];
        if (PAR != 0) exp_line[s+1+DW] = ^acc_word[j];
        exp_done[s+fl-1] = 1'b1;
        for (int k = s; k < s + fl; k++) exp_bhi[k] = 1'b1;
      end
      prev_end = s + fl;
    end
    for (int k = prev_end; k < n; k++) exp_blo[k] = 1'b1;
  endtask

  function automatic int diff_count(input int which);
    int   cnt = 0;
    logic a, e;
    for (int k = 0; k < cap_line.size(); k++) begin
      case (which)
        0: begin a = cap_line[k]; e = exp_line[k]; end
        1: begin a = cap_done[k]; e = exp_done[k]; end
        default: begin
          if (!exp_bhi[k] && !exp_blo[k]) continue;
          a = cap_busy[k];
          e = exp_bhi[k];
        end
      endcase
      if (a !== e) begin
        if (cnt == 0) begin bad_idx = k; bad_act = a; bad_exp = e; end
        cnt++;
      end
    end
    return cnt;
  endfunction

  task automatic test_reset();
    #1;
    tests_run++;
    if (from_mon2 !== 1'b0) begin tests_failed++; $display("FAIL reset_from_mon: got %b expected 0", from_mon2); end
    tests_run++;
    if (busy2 !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy2); end
    tests_run++;
    if (tx_done2 !== 1'b0) begin tests_failed++; $display("FAIL reset_tx_done: got %b expected 0", tx_done2); end
    tests_run++;
    if (in_ready2 !== 1'b1 || in_ready5 !== 1'b1) begin
      tests_failed++; $display("FAIL reset_in_ready: got %b/%b expected 1/1", in_ready2, in_ready5);
    end
    @(negedge mon_clk);
    reset = 1'b0;
  endtask

  task automatic test_single_frame();
    pend_q.delete();
    pend_q.push_back(40'h80_0000_0001);
    run_stream(FL2 + 20, 1'b0);
    build_expected();
    tests_run++;
    if (exp_fit !== 1 || acc_idx.size() !== 1 || acc_idx[0] !== 0) begin
      tests_failed++; $display("FAIL single_accept: accepted %0d words, first at %0d, expected 1 at 0", acc_idx.size(), acc_idx[0]);
    end
    tests_run++;
    nbad = diff_count(0);
    if (nbad !== 0) begin tests_failed++; $display("FAIL single_line: %0d bad, first at %0d got %b expected %b", nbad, bad_idx, bad_act, bad_exp); end
    tests_run++;
    nbad = diff_count(1);
    if (nbad !== 0) begin tests_failed++; $display("FAIL single_tx_done: %0d bad, first at %0d got %b expected %b", nbad, bad_idx, bad_act, bad_exp); end
    tests_run++;
    nbad = diff_count(2);
    if (nbad !== 0) begin tests_failed++; $display("FAIL single_busy: %0d bad, first at %0d got %b expected %b", nbad, bad_idx, bad_act, bad_exp); end
    tests_run++;
    if ({cap_line[2], cap_line[3], cap_line[4], cap_line[5], cap_line[43]} !== 5'b01101) begin
      tests_failed++;
      $display("FAIL single_bits: got %b%b%b%b%b expected 01101", cap_line[2], cap_line[3], cap_line[4], cap_line[5], cap_line[43]);
    end
    tests_run++;
    if (cap_done[FL2+2] !== 1'b1 || cap_line[FL2+2] !== 1'b0 || cap_line[FL2+1] !== 1'b0 || cap_done[FL2+1] !== 1'b0) begin
      tests_failed++; $display("FAIL single_last_gap: tx_done %b line %b expected 1 0", cap_done[FL2+2], cap_line[FL2+2]);
    end
    tests_run++;
    if (cap_busy[FL2+2] !== 1'b1 || cap_busy[FL2+3] !== 1'b0) begin
      tests_failed++; $display("FAIL single_busy_drop: got %b%b expected 10", cap_busy[FL2+2], cap_busy[FL2+3]);
    end
  endtask

  task automatic test_back_to_back();
    pend_q.delete();
    pend_q.push_back(40'hA5_A5A5_A5A5);
    pend_q.push_back(40'h00_0000_0000);
    pend_q.push_back(40'hFF_FFFF_FFFF);
    run_stream(3 * FL2 + 20, 1'b0);
    build_expected();
    tests_run++;
    if (acc_idx.size() !== 3 || acc_idx[1] !== 1 || acc_idx[2] !== 2 || exp_fit !== 1) begin
      tests_failed++; $display("FAIL b2b_accept: accepted %0d words, expected 3 on consecutive edges", acc_idx.size());
    end
    tests_run++;
    if (cap_ready[3] !== 1'b0 || cap_ready[2] !== 1'b1) begin
      tests_failed++; $display("FAIL b2b_in_ready: got %b%b expected 10", cap_ready[2], cap_ready[3]);
    end
    tests_run++;
    nbad = diff_count(0);
    if (nbad !== 0) begin tests_failed++; $display("FAIL b2b_line: %0d bad, first at %0d got %b expected %b", nbad, bad_idx, bad_act, bad_exp); end
    tests_run++;
    nbad = diff_count(1);
    if (nbad !== 0) begin tests_failed++; $display("FAIL b2b_tx_done: %0d bad, first at %0d got %b expected %b", nbad, bad_idx, bad_act, bad_exp); end
    tests_run++;
    nbad = diff_count(2);
    if (nbad !== 0) begin tests_failed++; $display("FAIL b2b_busy: %0d bad, first at %0d got %b expected %b", nbad, bad_idx, bad_act, bad_exp); end
  endtask

  task automatic test_hold_valid();
    pend_q.delete();
    pend_q.push_back(40'h12_3456_789A);
    pend_q.push_back(40'h0F_0F0F_0F0F);
    pend_q.push_back(40'hF0_F0F0_F0F0);
    pend_q.push_back(40'h55_AA55_AA55);
    run_stream(4 * FL2 + 20, 1'b1);
    build_expected();
    tests_run++;
    if (acc_idx.size() !== 4 || acc_idx[3] !== FL2 + 2 || exp_fit !== 1) begin
      tests_failed++; $display("FAIL hold_accept: 4th word at %0d expected %0d", acc_idx[3], FL2 + 2);
    end
    tests_run++;
    nbad = diff_count(0);
    if (nbad !== 0) begin tests_failed++; $display("FAIL hold_line: %0d bad, first at %0d got %b expected %b", nbad, bad_idx, bad_act, bad_exp); end
    tests_run++;
    nbad = diff_count(1);
    if (nbad !== 0) begin tests_failed++; $display("FAIL hold_tx_done: %0d bad, first at %0d got %b expected %b", nbad, bad_idx, bad_act, bad_exp); end
  endtask

  task automatic test_reset_midframe();
    int bad_line = 0, bad_done = 0, bad_busy = 0, bad_ready = 0;
    pend_q.delete();
    pend_q.push_back(40'hFF_FFFF_FFFF);
    pend_q.push_back(40'h12_3456_789A);
    run_stream(25, 1'b0);
    tests_run++;
    if (cap_line[24] !== 1'b1 || acc_idx.size() !== 2) begin
      tests_failed++; $display("FAIL midrst_pre: line %b words %0d expected 1 and 2", cap_line[24], acc_idx.size());
    end
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if (from_mon2 !== 1'b0) begin tests_failed++; $display("FAIL midrst_async_drop: got %b expected 0", from_mon2); end
    @(posedge mon_clk);
    @(negedge mon_clk);
    reset = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge mon_clk);
      if (from_mon2 !== 1'b0) bad_line++;
      if (tx_done2 !== 1'b0)  bad_done++;
      if (busy2 !== 1'b0)     bad_busy++;
      if (in_ready2 !== 1'b1) bad_ready++;
    end
    tests_run++;
    if (bad_line !== 0) begin tests_failed++; $display("FAIL midrst_line: %0d cycles nonzero, expected 0", bad_line); end
    tests_run++;
    if (bad_done !== 0) begin tests_failed++; $display("FAIL midrst_tx_done: %0d pulses, expected 0", bad_done); end
    tests_run++;
    if (bad_busy !== 0) begin tests_failed++; $display("FAIL midrst_busy: %0d cycles busy, expected 0", bad_busy); end
    tests_run++;
    if (bad_ready !== 0) begin tests_failed++; $display("FAIL midrst_in_ready: %0d cycles not ready, expected 0", bad_ready); end
  endtask

`ifdef MON_TX_PARITY_EN
  task automatic test_parity();
    int first_done = -1;
    pend_q.delete();
    pend_q.push_back(40'h00_0000_0007);
    pend_q.push_back(40'h00_0000_0003);
    run_stream(2 * FL2 + 20, 1'b0);
    build_expected();
    tests_run++;
    if (cap_line[44] !== 1'b1) begin tests_failed++; $display("FAIL parity_odd: got %b expected 1", cap_line[44]); end
    tests_run++;
    if (cap_line[47] !== 1'b1 || cap_line[88] !== 1'b0) begin
      tests_failed++; $display("FAIL parity_even: start %b parity %b expected 1 0", cap_line[47], cap_line[88]);
    end
    for (int k = cap_done.size() - 1; k >= 0; k--) if (cap_done[k] === 1'b1 && k < 60) first_done = k;
    tests_run++;
    if (first_done - 3 + 1 !== 44) begin tests_failed++; $display("FAIL parity_frame_len: got %0d expected 44", first_done - 2); end
    tests_run++;
    nbad = diff_count(0);
    if (nbad !== 0) begin tests_failed++; $display("FAIL parity_line: %0d bad, first at %0d got %b expected %b", nbad, bad_idx, bad_act, bad_exp); end
  endtask
`endif

  task automatic test_gap5();
    int k, zeros;
    sel5 = 1'b1;
    pend_q.delete();
    pend_q.push_back(40'hFF_FFFF_FFFF);
    pend_q.push_back(40'hFF_FFFF_FFFF);
    pend_q.push_back(40'h80_0000_0001);
    run_stream(3 * FL5 + 20, 1'b0);
    build_expected();
    k = 3;
    while (k < cap_line.size() && cap_line[k] === 1'b1) k++;
    zeros = 0;
    while (k < cap_line.size() && cap_line[k] === 1'b0) begin zeros++; k++; end
    tests_run++;
    if (zeros !== 5 + PAR) begin tests_failed++; $display("FAIL gap5_spacing: got %0d zeros expected %0d", zeros, 5 + PAR); end
    tests_run++;
    nbad = diff_count(0);
    if (nbad !== 0) begin tests_failed++; $display("FAIL gap5_line: %0d bad, first at %0d got %b expected %b", nbad, bad_idx, bad_act, bad_exp); end
    tests_run++;
    nbad = diff_count(1);
    if (nbad !== 0) begin tests_failed++; $display("FAIL gap5_tx_done: %0d bad, first at %0d got %b expected %b", nbad, bad_idx, bad_act, bad_exp); end
    sel5 = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    sel5     = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_hold_valid();
    test_reset_midframe();
`ifdef MON_TX_PARITY_EN
    test_parity();
`endif
    test_gap5();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
